// File: rtl/access_pkg.sv
// access_pkg: shared state encoding and default widths for access_sequencer
package access_pkg;
  localparam int DEF_TOKEN_W = 3;
  localparam int DEF_TIME_W = 8;
  localparam int TIMER_W = 8;
  localparam int FAIL_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT_CONFIRM,
    S_ACTIVE,
    S_CHECK_EXIT,
    S_DONE,
    S_LOCKED
  } state_t;
endpackage

// File: rtl/access_sequencer_timer.sv
// cycle_timer: loadable down-counter with expire flag, shared by confirm timeout and lockout
module cycle_timer
  import access_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_expired
);
  logic [TIMER_W-1:0] r_count;
  // load on request, otherwise count down and park at zero
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (r_count != '0) r_count <= r_count - 1'b1;
  assign o_expired = r_count == '0;
endmodule

// File: rtl/access_sequencer.sv
// access_sequencer: token-checked P/Q time capture sequencer; LOCKOUT_EN enables fail counting and lockout
module access_sequencer
  import access_pkg::*;
#(
  parameter int TOKEN_W = DEF_TOKEN_W,
  parameter int TIME_W = DEF_TIME_W,
  parameter int CONFIRM_TIMEOUT = 15
`ifdef LOCKOUT_EN
  , parameter int MAX_FAILS = 3,
  parameter int LOCK_CYCLES = 64
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_request,
  input  logic               i_confirm,
  input  logic [TOKEN_W-1:0] i_system_token,
  input  logic [TOKEN_W-1:0] i_user_token,
  input  logic [TIME_W-1:0]  i_time_data,
  output logic [TIME_W-1:0]  o_data_p,
  output logic [TIME_W-1:0]  o_data_q,
  output logic [TIME_W-1:0]  o_duration,
  output logic               o_load_p,
  output logic               o_load_q,
  output logic               o_granted,
  output logic               o_denied,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_locked
);
  state_t r_state, w_next;
  logic r_req_q;
  logic w_req_edge, w_match, w_expired, w_tok_fail, w_lock_hit, w_tmr_load;
  logic [TIMER_W-1:0] w_tmr_val;
  assign w_req_edge = i_request && !r_req_q;
  assign w_match = i_user_token == i_system_token;
  assign w_tok_fail = (r_state == S_CHECK || r_state == S_CHECK_EXIT) && !w_match;
`ifdef LOCKOUT_EN
  logic [FAIL_W-1:0] r_fail;
  assign w_lock_hit = w_tok_fail && (r_fail + FAIL_W'(1) >= FAIL_W'(MAX_FAILS));
  assign w_tmr_val = w_lock_hit ? TIMER_W'(LOCK_CYCLES - 1) : TIMER_W'(CONFIRM_TIMEOUT - 1);
  assign o_locked = r_state == S_LOCKED;
  // consecutive failure count, cleared by a grant or by the end of lockout
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_fail <= '0;
    else if (o_granted || (r_state == S_LOCKED && w_expired)) r_fail <= '0;
    else if (w_tok_fail) r_fail <= r_fail + FAIL_W'(1);
`else
  assign w_lock_hit = 1'b0;
  assign w_tmr_val = TIMER_W'(CONFIRM_TIMEOUT - 1);
  assign o_locked = 1'b0;
`endif
  // timer holds remaining cycles minus one so it expires in the last allowed cycle
  assign w_tmr_load = (r_state == S_CHECK && w_match) || w_lock_hit;
  cycle_timer u_timer (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_load(w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_expired(w_expired)
  );
  assign o_load_p = r_state == S_WAIT_CONFIRM && i_confirm;
  assign o_granted = o_load_p;
  assign o_load_q = r_state == S_CHECK_EXIT && w_match;
  assign o_done = r_state == S_DONE;
  assign o_denied = w_tok_fail || (r_state == S_WAIT_CONFIRM && !i_confirm && w_expired);
  assign o_busy = r_state != S_IDLE;
  // state register and request edge history
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_req_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req_q <= i_request;
    end
  // next-state: request edges outside IDLE/ACTIVE fall through untouched
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:         w_next = w_req_edge ? S_CHECK : S_IDLE;
      S_CHECK:        w_next = w_match ? S_WAIT_CONFIRM : w_lock_hit ? S_LOCKED : S_IDLE;
      S_WAIT_CONFIRM: w_next = i_confirm ? S_ACTIVE : w_expired ? S_IDLE : S_WAIT_CONFIRM;
      S_ACTIVE:       w_next = w_req_edge ? S_CHECK_EXIT : S_ACTIVE;
      S_CHECK_EXIT:   w_next = w_match ? S_DONE : w_lock_hit ? S_LOCKED : S_ACTIVE;
      S_DONE:         w_next = S_IDLE;
      S_LOCKED:       w_next = w_expired ? S_IDLE : S_LOCKED;
      default:        w_next = S_IDLE;
    endcase
  end
  // time capture; duration is taken with Q so it is valid alongside done
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_data_p <= '0;
      o_data_q <= '0;
      o_duration <= '0;
    end else begin
      if (o_load_p) o_data_p <= i_time_data;
      if (o_load_q) begin
        o_data_q <= i_time_data;
        o_duration <= i_time_data - o_data_p;
      end
    end
endmodule

// File: tb/tb_access_sequencer.sv
// tb_access_sequencer: table-driven and directed checks of access_sequencer
module tb_access_sequencer;
  localparam logic [6:0] LP = 7'b1000000, LQ = 7'b0100000, G = 7'b0010000,
                         DN = 7'b0001000, DO = 7'b0000100, B = 7'b0000010, LK = 7'b0000001;
  logic clk = 0, rst_n = 0, req = 0, conf = 0;
  logic [2:0] sys = 0, usr = 0;
  logic [7:0] tm = 0;
  logic [7:0] dp, dq, dur;
  logic lp, lq, gr, dn, dn_done, busy, lk;
  logic [7:0] ep = 0, eq = 0, ed = 0;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic r, c;
    logic [2:0] s, u;
    logic [7:0] t;
    logic [6:0] f;
    logic [7:0] p, q, d;
  } vec_t;
  vec_t tv[22];

  access_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(req), .i_confirm(conf),
    .i_system_token(sys), .i_user_token(usr), .i_time_data(tm),
    .o_data_p(dp), .o_data_q(dq), .o_duration(dur),
    .o_load_p(lp), .o_load_q(lq), .o_granted(gr), .o_denied(dn),
    .o_done(dn_done), .o_busy(busy), .o_locked(lk)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input bit r, input bit c, input int s, input int u, input int t,
                              input logic [6:0] f, input int p, input int q, input int d);
    vec_t v;
    v.r = r; v.c = c; v.s = 3'(s); v.u = 3'(u); v.t = 8'(t);
    v.f = f; v.p = 8'(p); v.q = 8'(q); v.d = 8'(d);
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [6:0] ef);
    logic [6:0] af;
    af = {lp, lq, gr, dn, dn_done, busy, lk};
    n_cmp++;
    if ({af, dp, dq, dur} !== {ef, ep, eq, ed}) begin
      n_bad++;
      $display("FAIL %s: got flags=%b P=%0d Q=%0d D=%0d, want flags=%b P=%0d Q=%0d D=%0d",
               nm, af, dp, dq, dur, ef, ep, eq, ed);
    end
  endtask

  task automatic step(input string nm, input logic [6:0] ef);
    @(negedge clk);
    cmp(nm, ef);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = mk(0, 0, 3, 3, 0,   0,      0,   0,  0);
    tv[1]  = mk(1, 0, 3, 3, 20,  0,      0,   0,  0);
    tv[2]  = mk(1, 0, 3, 3, 20,  B,      0,   0,  0);
    tv[3]  = mk(0, 1, 3, 3, 20,  B|LP|G, 0,   0,  0);
    tv[4]  = mk(0, 0, 3, 3, 20,  B,      20,  0,  0);
    tv[5]  = mk(1, 0, 3, 3, 55,  B,      20,  0,  0);
    tv[6]  = mk(1, 0, 3, 3, 55,  B|LQ,   20,  0,  0);
    tv[7]  = mk(1, 0, 3, 3, 55,  B|DO,   20,  55, 35);
    tv[8]  = mk(0, 0, 3, 3, 55,  0,      20,  55, 35);
    tv[9]  = mk(1, 0, 5, 2, 99,  0,      20,  55, 35);
    tv[10] = mk(1, 0, 5, 2, 99,  B|DN,   20,  55, 35);
    tv[11] = mk(0, 0, 5, 2, 99,  0,      20,  55, 35);
    tv[12] = mk(1, 0, 3, 3, 250, 0,      20,  55, 35);
    tv[13] = mk(1, 0, 3, 3, 250, B,      20,  55, 35);
    tv[14] = mk(0, 1, 3, 3, 250, B|LP|G, 20,  55, 35);
    tv[15] = mk(1, 0, 3, 3, 250, B,      250, 55, 35);
    tv[16] = mk(1, 0, 3, 2, 250, B|DN,   250, 55, 35);
    tv[17] = mk(0, 0, 3, 3, 4,   B,      250, 55, 35);
    tv[18] = mk(1, 0, 3, 3, 4,   B,      250, 55, 35);
    tv[19] = mk(1, 0, 3, 3, 4,   B|LQ,   250, 55, 35);
    tv[20] = mk(1, 0, 3, 3, 4,   B|DO,   250, 4,  10);
    tv[21] = mk(0, 0, 3, 3, 4,   0,      250, 4,  10);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset", 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // happy path, mismatches and wrap
    foreach (tv[i]) begin
      req = tv[i].r; conf = tv[i].c; sys = tv[i].s; usr = tv[i].u; tm = tv[i].t;
      ep = tv[i].p; eq = tv[i].q; ed = tv[i].d;
      step($sformatf("vec%0d", i), tv[i].f);
    end

    // timeout with a dropped request edge in WAIT_CONFIRM
    req = 1; sys = 3; usr = 3; conf = 0;
    step("to_idle", 0);
    step("to_check", B);
    for (int k = 1; k <= 15; k++) begin
      req = (k == 5);
      step($sformatf("to_wait%0d", k), k == 15 ? (B|DN) : B);
    end
    req = 0;
    step("to_back_idle", 0);

    // confirm in the timeout cycle wins
    req = 1;
    step("tc_idle", 0);
    step("tc_check", B);
    req = 0;
    for (int k = 1; k <= 15; k++) begin
      conf = (k == 15); tm = 77;
      step($sformatf("tc_wait%0d", k), k == 15 ? (B|LP|G) : B);
    end
    conf = 0; ep = 77;
    step("tc_active", B);

    // asynchronous reset while ACTIVE
    rst_n = 0;
    #1;
    ep = 0; eq = 0; ed = 0;
    cmp("async_reset", 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    req = 1; tm = 9;
    step("pr_idle", 0);
    step("pr_check", B);
    req = 0; conf = 1;
    step("pr_grant", B|LP|G);
    conf = 0; ep = 9;
    step("pr_active", B);
    req = 1; tm = 12;
    step("pr_exit_edge", B);
    step("pr_load_q", B|LQ);
    eq = 12; ed = 3;
    step("pr_done", B|DO);
    req = 0;
    step("pr_idle2", 0);

    // three consecutive mismatches
    sys = 5; usr = 2;
    for (int i = 0; i < 3; i++) begin
      req = 1;
      step($sformatf("mm%0d_idle", i), 0);
      step($sformatf("mm%0d_check", i), B|DN);
      req = 0;
`ifdef LOCKOUT_EN
      if (i < 2) step($sformatf("mm%0d_back", i), 0);
`else
      step($sformatf("mm%0d_back", i), 0);
`endif
    end
`ifdef LOCKOUT_EN
    for (int k = 1; k <= 64; k++) begin
      req = (k == 10);
      step($sformatf("lock%0d", k), B|LK);
    end
    req = 0;
    step("lock_exit", 0);
    req = 1; sys = 3; usr = 3;
    step("post_lock_idle", 0);
    step("post_lock_check", B);
`else
    req = 1;
    step("fourth_idle", 0);
    step("fourth_check", B|DN);
    req = 0;
    step("fourth_back", 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
